pe_mac_pipe: RTL

PE_MAC_PIPE -- requirements
Module: pe_mac_pipe

---
 rtl/pe_mac_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pe_mac_pipe.sv
// rtl/pe_mac_pipe.sv - two-stage signed multiply-accumulate processing element
//
// Purpose: S1 captures the opcode, the full-precision product data_a*weight and
// the addend. S2 applies the opcode to the accumulator and registers the result.
// Output is one beat per accepted beat, in order, with latency 2.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instruction[31:0]   opcode in [31:28] (1 MUL_ADD, 2 RELU, 3 MAC_ACC, 4 CLR, else NOP)
//   data_a, weight      signed multiplicand / multiplier (DATA_W)
//   data_b              signed addend for MUL_ADD (DATA_W)
//   in_valid, in_ready  input handshake
//   result              accumulator converted to DATA_W
//   out_valid, out_ready output handshake
//   sat_flag            clip indicator, qualified by out_valid
//
// Build option: PE_SATURATE_EN. When defined, acc saturates and result clips.
// When undefined, acc wraps, result is the low DATA_W bits and sat_flag is 0.
module pe_mac_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] data_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_flag
);

  localparam int PW = 2 * DATA_W;
`ifdef PE_SATURATE_EN
  // One guard bit lets the accumulator update detect overflow before clipping.
  localparam int SW = ACC_W + 1;
`else
  localparam int SW = ACC_W;
`endif

  localparam logic [3:0] OP_MUL_ADD = 4'h1;
  localparam logic [3:0] OP_RELU    = 4'h2;
  localparam logic [3:0] OP_MAC_ACC = 4'h3;
  localparam logic [3:0] OP_CLR     = 4'h4;

  logic                     s1_valid_q, s1_valid_d;
  logic [3:0]               s1_op_q, s1_op_d;
  logic signed [PW-1:0]     s1_prod_q, s1_prod_d;
  logic signed [DATA_W-1:0] s1_b_q, s1_b_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     out_valid_q, out_valid_d;

  logic                     advance;
  logic signed [SW-1:0]     sum;
  logic signed [ACC_W-1:0]  acc_new;
  logic [DATA_W-1:0]        res_new;

  logic unused_instr;
  assign unused_instr = ^instruction[27:0];

  // The whole pipe moves together whenever the output register is free.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

`ifdef PE_SATURATE_EN
  logic                     sat_q, sat_d;
  logic                     sat_new;
  logic                     acc_clip;
  logic                     res_clip;
  logic [ACC_W-DATA_W:0]    acc_hi;
`endif

  // S2 arithmetic reads acc_q directly, so consecutive MAC_ACC beats chain
  // without a bubble.
  always_comb begin
    sum = SW'(acc_q);
    case (s1_op_q)
      OP_MUL_ADD: sum = SW'(s1_prod_q) + SW'(s1_b_q);
      OP_MAC_ACC: sum = SW'(acc_q) + SW'(s1_prod_q);
      OP_RELU:    sum = acc_q[ACC_W-1] ? '0 : SW'(acc_q);
      OP_CLR:     sum = '0;
      default:    ;
    endcase
`ifdef PE_SATURATE_EN
    acc_clip = sum[SW-1] != sum[SW-2];
    if (acc_clip) begin
      acc_new = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_new = sum[ACC_W-1:0];
    end
    // acc fits in DATA_W only when all bits above the result sign bit agree.
    acc_hi   = acc_new[ACC_W-1:DATA_W-1];
    res_clip = !((&acc_hi) || !(|acc_hi));
    if (res_clip) begin
      res_new = acc_new[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res_new = acc_new[DATA_W-1:0];
    end
    sat_new = acc_clip || res_clip;
`else
    acc_new = sum;
    res_new = acc_new[DATA_W-1:0];
`endif
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_prod_d   = s1_prod_q;
    s1_b_d      = s1_b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef PE_SATURATE_EN
    sat_d       = sat_q;
`endif
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d   = instruction[31:28];
        s1_prod_d = $signed({{DATA_W{data_a[DATA_W-1]}}, data_a}) *
                    $signed({{DATA_W{weight[DATA_W-1]}}, weight});
        s1_b_d    = data_b;
      end
      out_valid_d = s1_valid_q;
      // A bubble in S1 leaves acc and the last result untouched.
      if (s1_valid_q) begin
        acc_d    = acc_new;
        result_d = res_new;
`ifdef PE_SATURATE_EN
        sat_d    = sat_new;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_prod_q   <= '0;
      s1_b_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef PE_SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_prod_q   <= s1_prod_d;
      s1_b_q      <= s1_b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
`ifdef PE_SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
`ifdef PE_SATURATE_EN
  assign sat_flag  = sat_q;
`else
  assign sat_flag  = 1'b0;
`endif

endmodule
